// File: rtl/led_code_arbiter_if.sv
// led_code_arbiter_if: request/code inputs and grant/status/LED outputs of the LED code arbiter.
interface led_code_arbiter_if;
   logic [3:0]  i_req;
   logic [15:0] i_code;
   logic [3:0]  o_grant;
   logic        o_busy;
   logic        o_done;
   logic        o_led;
   modport slave  (input i_req, i_code, output o_grant, o_busy, o_done, o_led);
   modport master (output i_req, i_code, input o_grant, o_busy, o_done, o_led);
endinterface

// File: rtl/led_code_arbiter.sv
// led_code_arbiter: round-robin arbiter that blinks the winner's 4-bit code on a shared LED.
// Optional idle heartbeat on the LED is enabled by defining LED_ARB_HEARTBEAT_EN.
module led_code_arbiter #(
   parameter int PRESCALE_BITS = 22,
   parameter int PAUSE_TICKS   = 4,
   parameter int HB_BITS       = 26
) (
   input  logic              i_clk,
   input  logic              i_reset,
   led_code_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_PAUSE} state_t;
   state_t                   r_state;
   logic [PRESCALE_BITS-1:0] r_pres;
   logic [3:0]               r_rem;
   logic [3:0]               r_pcnt;
   logic [1:0]               r_last;
   logic [3:0]               r_grant;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_led;
   logic [1:0]               w_idx;
   logic [3:0]               w_code;
   logic                     w_tick;
   logic                     w_hb_led;
   assign w_tick = &r_pres;
   assign w_code = bus.i_code[{w_idx, 2'b00} +: 4];
   // Scan downward so the nearest requester after r_last is the final (winning) assignment.
   always_comb begin
      w_idx = r_last;
      for (int k = 3; k >= 0; k--)
         if (bus.i_req[r_last + 2'(k) + 2'd1]) w_idx = r_last + 2'(k) + 2'd1;
   end
`ifdef LED_ARB_HEARTBEAT_EN
   logic [HB_BITS-1:0] r_hb;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) r_hb <= '0;
      else r_hb <= r_hb + 1'b1;
   assign w_hb_led = r_hb[HB_BITS-1];
`else
   assign w_hb_led = 1'b0;
`endif
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_pres  <= '0;
         r_rem   <= '0;
         r_pcnt  <= '0;
         r_last  <= 2'd3;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_pres <= r_pres + 1'b1;
         case (r_state)
            S_IDLE:
               if (|bus.i_req) begin
                  r_state <= (w_code != 4'd0) ? S_ON : S_PAUSE;
                  r_grant <= 4'b0001 << w_idx;
                  r_last  <= w_idx;
                  r_rem   <= w_code;
                  r_pres  <= '0;
                  r_pcnt  <= '0;
                  r_busy  <= 1'b1;
                  r_led   <= (w_code != 4'd0);
               end else r_led <= w_hb_led;
            S_ON:
               if (w_tick) begin
                  r_rem   <= r_rem - 1'b1;
                  r_state <= S_OFF;
                  r_led   <= 1'b0;
               end
            S_OFF:
               if (w_tick) begin
                  r_state <= (r_rem != 4'd0) ? S_ON : S_PAUSE;
                  r_led   <= (r_rem != 4'd0);
                  r_pcnt  <= '0;
               end
            S_PAUSE:
               if (w_tick) begin
                  if (r_pcnt == 4'(PAUSE_TICKS - 1)) begin
                     r_state <= S_IDLE;
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_led   <= w_hb_led;
                  end else r_pcnt <= r_pcnt + 1'b1;
               end
         endcase
      end
   end
   assign bus.o_grant = r_grant;
   assign bus.o_busy  = r_busy;
   assign bus.o_done  = r_done;
   assign bus.o_led   = r_led;
endmodule

// File: tb/tb_led_code_arbiter.sv
// tb_led_code_arbiter: directed vector table plus reset/rotation sequences for led_code_arbiter.
module tb_led_code_arbiter;
   localparam int PB = 2;
   localparam int PT = 4;
   localparam int PH = 1 << PB;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   led_code_arbiter_if bus();
   led_code_arbiter #(.PRESCALE_BITS(PB), .PAUSE_TICKS(PT), .HB_BITS(3)) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  req;
      logic [15:0] code;
      logic [3:0]  grant;
      int          n;
   } vec_t;
   vec_t vecs[7];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Apply one request from IDLE, then withdraw it and scramble the codes while it plays.
   task automatic run_vec(input vec_t v);
      int t;
      int bad;
      bus.i_req  = v.req;
      bus.i_code = v.code;
      @(negedge clk);
      chk("grant", {28'd0, bus.o_grant}, {28'd0, v.grant});
      chk("busy", {31'd0, bus.o_busy}, 32'd1);
      bus.i_req  = 4'd0;
      bus.i_code = ~v.code;
      t = 0;
      bad = 0;
      while (!bus.o_done && t < 300) begin
         if (bus.o_led !== ((t < 2 * PH * v.n) && ((t % (2 * PH)) < PH))) bad++;
         if (bus.o_grant !== v.grant) bad++;
         @(negedge clk);
         t++;
      end
      chk("length", t, (2 * v.n + PT) * PH);
      chk("led_pattern", bad, 0);
      chk("idle_on_done", {27'd0, bus.o_grant, bus.o_busy}, 32'd0);
      @(negedge clk);
      chk("done_pulse", {31'd0, bus.o_done}, 32'd0);
   endtask
   initial begin
      int t;
      logic [3:0] exp_g[5];
      vecs[0] = '{4'b0001, 16'h0003, 4'b0001, 3};
      vecs[1] = '{4'b0001, 16'h0000, 4'b0001, 0};
      vecs[2] = '{4'b1001, 16'h2005, 4'b1000, 2};
      vecs[3] = '{4'b0110, 16'h0510, 4'b0010, 1};
      vecs[4] = '{4'b0011, 16'h0094, 4'b0001, 4};
      vecs[5] = '{4'b1100, 16'h7F00, 4'b0100, 15};
      vecs[6] = '{4'b0100, 16'h0200, 4'b0100, 2};
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      bus.i_req  = 4'd0;
      bus.i_code = 16'd0;
      @(negedge clk);
      chk("reset_outputs", {25'd0, bus.o_grant, bus.o_busy, bus.o_done, bus.o_led}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_grant", {28'd0, bus.o_grant}, 32'd0);
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);
      // Reset during the second ON phase, then requester 0 must win again.
      bus.i_req  = 4'b0101;
      bus.i_code = 16'h0103;
      @(negedge clk);
      chk("pre_reset_grant", {28'd0, bus.o_grant}, 32'h1);
      repeat (9) @(negedge clk);
      chk("second_on_led", {31'd0, bus.o_led}, 32'd1);
      #1 rst = 1'b1;
      #1 chk("reset_abort", {25'd0, bus.o_grant, bus.o_busy, bus.o_done, bus.o_led}, 32'd0);
      @(negedge clk);
      chk("reset_no_done", {31'd0, bus.o_done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("grant_after_reset", {28'd0, bus.o_grant}, 32'h1);
      bus.i_req = 4'd0;
      t = 0;
      while (!bus.o_done && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("length_after_reset", t, (2 * 3 + PT) * PH);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      // All four requesters held high: strict rotation, one IDLE cycle between grants.
      bus.i_req  = 4'b1111;
      bus.i_code = 16'h1111;
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
         int cnt;
         chk("rr_grant", {28'd0, bus.o_grant}, {28'd0, exp_g[g]});
         cnt = 0;
         while (bus.o_grant === exp_g[g] && cnt < 100) begin
            @(negedge clk);
            cnt++;
         end
         chk("rr_grant_len", cnt, (2 + PT) * PH);
         chk("rr_gap_done", {27'd0, bus.o_grant, bus.o_done}, 32'd1);
         if (g == 4) bus.i_req = 4'd0;
         @(negedge clk);
      end
      chk("rr_idle_after", {28'd0, bus.o_grant}, 32'd0);
`ifdef LED_ARB_HEARTBEAT_EN
      begin
         int ch;
         logic p;
         ch = 0;
         p = bus.o_led;
         repeat (16) begin
            @(negedge clk);
            if (bus.o_led !== p) ch++;
            p = bus.o_led;
         end
         chk("heartbeat_toggles", ch, 4);
      end
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/led_code_arbiter.md
LED_CODE_ARBITER -- requirements
Module: led_code_arbiter

Interface
REQ-001 Parameter PRESCALE_BITS, default 22: phase-length counter width; one tick = 2^PRESCALE_BITS clocks.
REQ-002 Parameter PAUSE_TICKS, default 4: inter-code pause length in ticks, range 1..15.
REQ-003 Parameter HB_BITS, default 26: heartbeat counter width, used only with LED_ARB_HEARTBEAT_EN.
REQ-004 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  4  per-requester request; bit n = requester n.
REQ-007 i_code  input  16  blink count per requester; i_code[4n+3:4n] for requester n, 0..15.
REQ-008 o_grant  output  4  one-hot grant, all zero when idle.
REQ-009 o_busy  output  1  high while a code is being played (state != IDLE).
REQ-010 o_done  output  1  one-cycle pulse on completion of a playback.
REQ-011 o_led  output  1  shared LED drive.

Function
REQ-012 FSM states: IDLE, ON, OFF, PAUSE; all outputs registered.
REQ-013 IDLE with any i_req bit set: round-robin select, searching upward from (last_grant+1) mod 4; latch selected 4-bit code; clear prescaler; set o_grant one-hot next cycle.
REQ-014 Entry from IDLE: latched code != 0 -> ON; code == 0 -> PAUSE directly, LED never lit.
REQ-015 Tick = prescaler equal to all ones; prescaler wraps to 0 on tick; each phase lasts exactly 2^PRESCALE_BITS clocks.
REQ-016 ON: o_led=1; on tick decrement remaining count, go OFF.
REQ-017 OFF: o_led=0; on tick go ON if remaining != 0, else PAUSE.
REQ-018 PAUSE: o_led=0; after PAUSE_TICKS ticks go IDLE, clear o_grant and o_busy, assert o_done for one cycle during that first IDLE cycle.
REQ-019 Arbitration SHALL also be evaluated in the o_done cycle; minimum gap between consecutive grants is one IDLE cycle.
REQ-020 Code and winner latched at grant; later changes of i_req or i_code SHALL NOT affect an active playback, and dropping i_req SHALL NOT abort it.
REQ-021 Requests arriving while busy SHALL be held off (no grant change) until IDLE; requesters keep i_req high to retain their turn.
REQ-022 last_grant pointer updates only when a grant is issued.
REQ-023 Playback of code N SHALL occupy exactly (2*N + PAUSE_TICKS) * 2^PRESCALE_BITS clocks from grant to o_done.

Reset
REQ-024 i_reset SHALL immediately force state IDLE, o_grant=0, o_busy=0, o_done=0, o_led=0, prescaler=0, remaining=0, last_grant=3 (requester 0 first).
REQ-025 Reset asserted mid-playback SHALL abort it with no o_done pulse; after release the arbiter restarts from IDLE.

Configuration
REQ-026 Macro LED_ARB_HEARTBEAT_EN defined: free-running HB_BITS counter; in IDLE o_led = counter MSB; counter not reset by grants, cleared only by i_reset.
REQ-027 Macro undefined: no heartbeat counter, o_led=0 in IDLE; all other behaviour identical.

Verification (PRESCALE_BITS=2, PAUSE_TICKS=4, macro undefined unless stated)
REQ-028 i_req=0001, code0=3 -> grant 0001 next cycle; LED high 4 / low 4 clocks x3; o_done pulse exactly 40 clocks after grant.
REQ-029 i_req=1111 held, all codes=1 -> grants 0001,0010,0100,1000,0001 in order, each 24 clocks, one IDLE cycle between.
REQ-030 code0=0 -> o_led stays 0, o_done 16 clocks after grant.
REQ-031 Drop i_req and change i_code mid-playback -> playback length and LED pattern unchanged.
REQ-032 Assert i_reset during second ON phase -> all outputs 0 same cycle, no o_done; next request granted normally to requester 0 priority.
REQ-033 LED_ARB_HEARTBEAT_EN, HB_BITS=3, no requests -> o_led toggles every 4 clocks; on grant LED follows code pattern.
